// File: rtl/imem_loader.sv
// Boot-time loader: assembles a length-prefixed, XOR-checksummed byte stream into
// little-endian words, writes them into the instruction SRAM, then releases the core.
module imem_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned MAX_WORDS = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [3:0]  im_w_en,
  output logic [15:0] im_address,
  output logic [31:0] im_write_data,
  output logic        core_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_written
);

  // state | meaning
  // IDLE  | one settling cycle after reset
  // LEN0  | waiting for word count low byte
  // LEN1  | waiting for word count high byte
  // DATA  | collecting the 4 bytes of the current word
  // WRITE | single-cycle full-word write to the SRAM
  // CSUM  | waiting for the trailing checksum byte
  // DONE  | load good, core released (terminal)
  // ERR   | load aborted, core held (terminal)
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    CSUM  = 3'd5,
    DONE  = 3'd6,
    ERR   = 3'd7
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_count, w_count_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic [7:0]  r_csum, w_csum_nxt;
  logic [31:0] r_word, w_word_nxt;
  logic [15:0] r_addr, w_addr_nxt;
  logic [15:0] r_words, w_words_nxt;

  logic        w_accept;
  logic        w_xfer;
  logic [15:0] w_len;

  assign w_accept = (r_state == LEN0) || (r_state == LEN1) ||
                    (r_state == DATA) || (r_state == CSUM);
  assign w_xfer   = in_valid && w_accept;
  assign w_len    = {in_data, r_count[7:0]};

  assign im_address    = r_addr;
  assign im_write_data = r_word;
  assign words_written = r_words;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_count <= 16'h0000;
      r_idx   <= 2'd0;
      r_csum  <= 8'h00;
      r_word  <= 32'h0000_0000;
      r_addr  <= BASE_ADDR;
      r_words <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_idx   <= w_idx_nxt;
      r_csum  <= w_csum_nxt;
      r_word  <= w_word_nxt;
      r_addr  <= w_addr_nxt;
      r_words <= w_words_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_idx_nxt   = r_idx;
    w_csum_nxt  = r_csum;
    w_word_nxt  = r_word;
    w_addr_nxt  = r_addr;
    w_words_nxt = r_words;
    in_ready    = w_accept;
    im_w_en     = 4'h0;
    core_hold   = 1'b1;
    done        = 1'b0;
    error       = 1'b0;

    case (r_state)
      IDLE: w_state_nxt = LEN0;
      LEN0: begin
        if (w_xfer) begin
          w_count_nxt[7:0] = in_data;
          w_csum_nxt       = r_csum ^ in_data;
          w_state_nxt      = LEN1;
        end
      end
      LEN1: begin
        if (w_xfer) begin
          w_count_nxt = w_len;
          w_csum_nxt  = r_csum ^ in_data;
          w_idx_nxt   = 2'd0;
          if ({16'h0000, w_len} > 32'(MAX_WORDS)) w_state_nxt = ERR;
          else if (w_len == 16'h0000)           w_state_nxt = CSUM;
          else                                  w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_xfer) begin
          w_word_nxt[8*r_idx +: 8] = in_data;
          w_csum_nxt = r_csum ^ in_data;
          w_idx_nxt  = r_idx + 2'd1;
          if (r_idx == 2'd3) w_state_nxt = WRITE;
        end
      end
      WRITE: begin
        im_w_en     = 4'hF;
        w_addr_nxt  = r_addr + 16'd4;
        w_words_nxt = r_words + 16'd1;
        // r_idx has already wrapped back to 0 for the next word
        if (w_words_nxt == r_count) w_state_nxt = CSUM;
        else                        w_state_nxt = DATA;
      end
      CSUM: begin
        if (w_xfer) w_state_nxt = (in_data == r_csum) ? DONE : ERR;
      end
      DONE: begin
        done      = 1'b1;
        core_hold = 1'b0;
      end
      ERR: error = 1'b1;
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: three instances (default, MAX_WORDS=4, BASE_ADDR=0x0100)
// share one byte stream; writes are captured per instance and compared to hand-computed values.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;

  logic        rdy0, rdy1, rdy2;
  logic [3:0]  wen0, wen1, wen2;
  logic [15:0] addr0, addr1, addr2;
  logic [31:0] wd0, wd1, wd2;
  logic        hold0, hold1, hold2;
  logic        done0, done1, done2;
  logic        err0, err1, err2;
  logic [15:0] nw0, nw1, nw2;
  logic [2:0]  rdy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] qa0[$];
  logic [31:0] qd0[$];
  logic [3:0]  qw0[$];
  logic [15:0] qa2[$];
  logic [31:0] qd2[$];
  int          wr_cnt1;
  logic        px0, px2;

  always #5 clk = ~clk;

  imem_loader u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
    .im_w_en(wen0), .im_address(addr0), .im_write_data(wd0), .core_hold(hold0),
    .done(done0), .error(err0), .words_written(nw0)
  );

  imem_loader #(.MAX_WORDS(4)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
    .im_w_en(wen1), .im_address(addr1), .im_write_data(wd1), .core_hold(hold1),
    .done(done1), .error(err1), .words_written(nw1)
  );

  imem_loader #(.BASE_ADDR(16'h0100)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy2),
    .im_w_en(wen2), .im_address(addr2), .im_write_data(wd2), .core_hold(hold2),
    .done(done2), .error(err2), .words_written(nw2)
  );

  assign rdy = {rdy2, rdy1, rdy0};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) begin
    px0 <= in_valid && rdy0;
    px2 <= in_valid && rdy2;
  end

  // Capture writes; each must land one cycle after an accepted byte with in_ready low
  always @(negedge clk) begin
    if (rst === 1'b1 && wen0 !== 4'h0) begin
      qa0.push_back(addr0);
      qd0.push_back(wd0);
      qw0.push_back(wen0);
      check("wr0_in_ready", {31'd0, rdy0}, 32'd0);
      check("wr0_latency", {31'd0, px0}, 32'd1);
    end
    if (rst === 1'b1 && wen2 !== 4'h0) begin
      qa2.push_back(addr2);
      qd2.push_back(wd2);
      check("wr2_latency", {31'd0, px2}, 32'd1);
    end
    if (rst === 1'b1 && wen1 !== 4'h0) wr_cnt1++;
  end

  task automatic clear_caps();
    qa0.delete(); qd0.delete(); qw0.delete();
    qa2.delete(); qd2.delete();
    wr_cnt1 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    clear_caps();
  endtask

  // Offer one byte from the negedge; returns at the negedge after it transfers into instance sel
  task automatic send_byte(input int sel, input logic [7:0] b, input bit gap);
    bit ok;
    ok = 1'b0;
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int k = 0; k < 20 && !ok; k++) begin
      #1;
      if (rdy[sel]) ok = 1'b1;
      @(negedge clk);
    end
    if (!ok) check("handshake_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_stream(input int sel, input logic [7:0] s[], input bit gap);
    for (int i = 0; i < s.size(); i++) send_byte(sel, s[i], gap);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_nominal_writes(input string t);
    check({t, "_nwr0"}, qa0.size(), 32'd2);
    check({t, "_nwr2"}, qa2.size(), 32'd2);
    if (qa0.size() == 2) begin
      check({t, "_a0_0"}, {16'd0, qa0[0]}, 32'h0000);
      check({t, "_d0_0"}, qd0[0], 32'h0000_0013);
      check({t, "_w0_0"}, {28'd0, qw0[0]}, 32'hF);
      check({t, "_a0_1"}, {16'd0, qa0[1]}, 32'h0004);
      check({t, "_d0_1"}, qd0[1], 32'h1234_5678);
      check({t, "_w0_1"}, {28'd0, qw0[1]}, 32'hF);
    end
    if (qa2.size() == 2) begin
      check({t, "_a2_0"}, {16'd0, qa2[0]}, 32'h0100);
      check({t, "_a2_1"}, {16'd0, qa2[1]}, 32'h0104);
      check({t, "_d2_1"}, qd2[1], 32'h1234_5678);
    end
  endtask

  logic [7:0] nominal[] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                            8'h78, 8'h56, 8'h34, 8'h12, 8'h19};
  logic [7:0] badsum[]  = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                            8'h78, 8'h56, 8'h34, 8'h12, 8'h18};
  logic [7:0] zero[]    = '{8'h00, 8'h00, 8'h00};

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    wr_cnt1  = 0;
    #12;
    check("rst_ready", {31'd0, rdy0}, 32'd0);
    check("rst_wen", {28'd0, wen0}, 32'd0);
    check("rst_addr0", {16'd0, addr0}, 32'h0000);
    check("rst_addr2", {16'd0, addr2}, 32'h0100);
    check("rst_wdata", wd0, 32'd0);
    check("rst_hold", {31'd0, hold0}, 32'd1);
    check("rst_done_err", {30'd0, done0, err0}, 32'd0);
    check("rst_nw", {16'd0, nw0}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    clear_caps();

    // nominal, gap-free
    send_stream(0, nominal, 1'b0);
    check_nominal_writes("nom");
    check("nom_done", {31'd0, done0}, 32'd1);
    check("nom_hold", {31'd0, hold0}, 32'd0);
    check("nom_nw", {16'd0, nw0}, 32'd2);
    check("nom_err", {31'd0, err0}, 32'd0);
    check("nom_done2", {31'd0, done2}, 32'd1);

    // zero length
    do_reset();
    send_stream(0, zero, 1'b0);
    check("zero_nwr", qa0.size(), 32'd0);
    check("zero_done", {31'd0, done0}, 32'd1);
    check("zero_hold", {31'd0, hold0}, 32'd0);

    // bad checksum
    do_reset();
    send_stream(0, badsum, 1'b0);
    check("bad_nwr", qa0.size(), 32'd2);
    check("bad_err", {31'd0, err0}, 32'd1);
    check("bad_done", {31'd0, done0}, 32'd0);
    check("bad_hold", {31'd0, hold0}, 32'd1);
    check("bad_ready", {31'd0, rdy0}, 32'd0);

    // oversize on the MAX_WORDS=4 instance
    do_reset();
    send_byte(1, 8'h05, 1'b0);
    send_byte(1, 8'h00, 1'b0);
    #1;
    check("over_err", {31'd0, err1}, 32'd1);
    check("over_ready", {31'd0, rdy1}, 32'd0);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (8) @(negedge clk);
    #1;
    check("over_still_ready", {31'd0, rdy1}, 32'd0);
    check("over_still_err", {30'd0, err1, done1}, 32'd2);
    check("over_nwr", wr_cnt1, 32'd0);
    check("over_nw", {16'd0, nw1}, 32'd0);
    in_valid = 1'b0;

    // nominal with in_valid gaps
    do_reset();
    send_stream(0, nominal, 1'b1);
    check_nominal_writes("gap");
    check("gap_done", {31'd0, done0}, 32'd1);
    check("gap_nw", {16'd0, nw0}, 32'd2);

    // reset in the middle of a load, asserted between edges
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(2, nominal[i], 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("mid_wen", {28'd0, wen2}, 32'd0);
    check("mid_addr", {16'd0, addr2}, 32'h0100);
    check("mid_ready", {31'd0, rdy2}, 32'd0);
    check("mid_hold", {31'd0, hold2}, 32'd1);
    check("mid_nw", {16'd0, nw2}, 32'd0);
    check("mid_wdata", wd2, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    clear_caps();
    send_stream(2, nominal, 1'b0);
    check_nominal_writes("rel");
    check("rel_done2", {31'd0, done2}, 32'd1);
    check("rel_nw2", {16'd0, nw2}, 32'd2);
    check("rel_addr2", {16'd0, addr2}, 32'h0108);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
